window_scan_ctrl_3x3: RTL and testbench

Raster-scan controller that sequences the 3x3 data-modulation path over one ROWS x COLS frame. It counts pixels shifted into the upstream line-buffer window and tracks the (row, col) of the current window centre. It also flags which of the nine taps lie inside the image, and generates the flush shifts needed to drain the last COLS+1 centres after input ends. It sits between the pixel source and the 3x3 window/modulation datapath and replaces ad-hoc done/start counting there.

---
 rtl/window_scan_ctrl_3x3_pkg.sv | 38 +++
 rtl/window_scan_ctrl_3x3_pos_tracker.sv | 74 +++++++
 rtl/window_scan_ctrl_3x3.sv | 99 +++++++++
 tb/tb_window_scan_ctrl_3x3.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/window_scan_ctrl_3x3_pkg.sv
// Shared state encoding, tap indices and border-mask constants for the 3x3 scan controller.
package window_scan_ctrl_3x3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

  localparam logic [8:0] MASK_ALL   = 9'h1FF;
  localparam logic [8:0] MASK_TOP   = 9'h007;
  localparam logic [8:0] MASK_BOT   = 9'h1C0;
  localparam logic [8:0] MASK_LEFT  = 9'h049;
  localparam logic [8:0] MASK_RIGHT = 9'h124;

  function automatic logic [8:0] border_mask(input logic top, input logic bot,
                                             input logic left, input logic right);
    logic [8:0] m;
    m = MASK_ALL;
    if (top)   m = m & ~MASK_TOP;
    if (bot)   m = m & ~MASK_BOT;
    if (left)  m = m & ~MASK_LEFT;
    if (right) m = m & ~MASK_RIGHT;
    return m;
  endfunction

endpackage

// File: rtl/window_scan_ctrl_3x3_pos_tracker.sv
// Window centre (row, col) tracking and tap-validity mask, advanced by an emit strobe.
// Border masking is built only with BORDER_MASK_EN; otherwise every emitted mask is all-ones.
module window_pos_tracker
  import window_scan_ctrl_3x3_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_emit,
  output logic          o_valid,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic [8:0]    o_mask
);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [RW-1:0] r_next_row;
  logic [CW-1:0] r_next_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [8:0]    r_mask;
  logic          r_valid;
  logic [8:0]    w_mask_next;

`ifdef BORDER_MASK_EN
  localparam logic [8:0] MASK_RST = MASK_ALL;
  assign w_mask_next = border_mask(r_next_row == '0, r_next_row == ROW_LAST,
                                   r_next_col == '0, r_next_col == COL_LAST);
`else
  localparam logic [8:0] MASK_RST = 9'h000;
  assign w_mask_next = MASK_ALL;
`endif

  // r_next_* is the position the next emit will present; outputs hold between emits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_next_row <= '0;
      r_next_col <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_mask     <= MASK_RST;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= i_emit;
      if (i_clear) begin
        r_next_row <= '0;
        r_next_col <= '0;
      end else if (i_emit) begin
        r_row  <= r_next_row;
        r_col  <= r_next_col;
        r_mask <= w_mask_next;
        if (r_next_col == COL_LAST) begin
          r_next_col <= '0;
          if (r_next_row != ROW_LAST) r_next_row <= r_next_row + 1'b1;
        end else begin
          r_next_col <= r_next_col + 1'b1;
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_row   = r_row;
  assign o_col   = r_col;
  assign o_mask  = r_mask;

endmodule

// File: rtl/window_scan_ctrl_3x3.sv
// Raster-scan sequencer for the 3x3 window datapath: counts shifts, drives flush, flags windows.
// Optional border tap masking is enabled with the BORDER_MASK_EN macro.
//
//   state | meaning
//   IDLE  | waiting for start_i
//   RUN   | accepting pixels on valid_i
//   FLUSH | shifting COLS+1 zero pixels to drain the last centres
//   DONE  | one-cycle frame wrap-up
module window_scan_ctrl_3x3
  import window_scan_ctrl_3x3_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    valid_i,
  output logic                    flush_o,
  output logic                    busy_o,
  output logic                    window_valid_o,
  output logic [$clog2(ROWS)-1:0] row_o,
  output logic [$clog2(COLS)-1:0] col_o,
  output logic [8:0]              mask_o,
  output logic                    done_o
);

  localparam int PIX  = ROWS * COLS;
  localparam int SH_W = $clog2(PIX + COLS + 1);
  localparam int FL_W = $clog2(COLS + 2);
  localparam logic [SH_W-1:0] SH_LAST  = SH_W'(PIX - 1);
  localparam logic [SH_W-1:0] SH_FIRST = SH_W'(COLS + 1);
  localparam logic [FL_W-1:0] FL_LAST  = FL_W'(COLS);

  scan_state_t r_state, w_state_next;
  logic [SH_W-1:0] r_sh_cnt;
  logic [FL_W-1:0] r_flush_cnt;
  logic            r_done;
  logic            w_start;
  logic            w_shift;
  logic            w_emit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (start_i) w_state_next = RUN;
      RUN:   if (valid_i && r_sh_cnt == SH_LAST) w_state_next = FLUSH;
      FLUSH: if (r_flush_cnt == FL_LAST) w_state_next = DONE;
      DONE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    flush_o = (r_state == FLUSH);
    busy_o  = (r_state != IDLE);
    w_start = (r_state == IDLE) && start_i;
    w_shift = ((r_state == RUN) && valid_i) || (r_state == FLUSH);
    // a centre exists only once COLS+1 pixels precede it in the window
    w_emit  = w_shift && (r_sh_cnt >= SH_FIRST);
  end

  // done_o trails the final window by one cycle, so it is registered off DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_cnt    <= '0;
      r_flush_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (w_start)      r_sh_cnt <= '0;
      else if (w_shift) r_sh_cnt <= r_sh_cnt + 1'b1;
      if (r_state == FLUSH) r_flush_cnt <= r_flush_cnt + 1'b1;
      else                  r_flush_cnt <= '0;
    end
  end

  assign done_o = r_done;

  window_pos_tracker #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start),
    .i_emit  (w_emit),
    .o_valid (window_valid_o),
    .o_row   (row_o),
    .o_col   (col_o),
    .o_mask  (mask_o)
  );

endmodule

// File: tb/tb_window_scan_ctrl_3x3.sv
// Scoreboard bench for window_scan_ctrl_3x3: stimulus pushes expected windows/flush/done events,
// a negedge monitor pops and compares them. Mask model follows BORDER_MASK_EN.
module tb_window_scan_ctrl_3x3;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int PIX  = ROWS * COLS;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       valid_i;
  logic       flush_o;
  logic       busy_o;
  logic       window_valid_o;
  logic [2:0] row_o;
  logic [2:0] col_o;
  logic [8:0] mask_o;
  logic       done_o;

  window_scan_ctrl_3x3 #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .valid_i        (valid_i),
    .flush_o        (flush_o),
    .busy_o         (busy_o),
    .window_valid_o (window_valid_o),
    .row_o          (row_o),
    .col_o          (col_o),
    .mask_o         (mask_o),
    .done_o         (done_o)
  );

  typedef struct {
    int         tag;
    int         row;
    int         col;
    logic [8:0] mask;
  } win_t;

  win_t q_win[$];
  int   q_flush[$];
  int   q_done[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

`ifdef BORDER_MASK_EN
  localparam logic [8:0] MASK_RESET = 9'h1FF;
`else
  localparam logic [8:0] MASK_RESET = 9'h000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: %s", name, cyc, detail);
  endtask

  // Tap k is inside when its neighbour position lies within the frame
  function automatic logic [8:0] exp_mask(input int r, input int c);
    logic [8:0] m;
    m = 9'h1FF;
`ifdef BORDER_MASK_EN
    for (int k = 0; k < 9; k++) begin
      int rr;
      int cc;
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
      m[k] = (rr >= 0) && (rr < ROWS) && (cc >= 0) && (cc < COLS);
    end
`endif
    return m;
  endfunction

  function automatic win_t mk_win(input int idx, input int tag);
    win_t w;
    w.tag  = tag;
    w.row  = idx / COLS;
    w.col  = idx % COLS;
    w.mask = exp_mask(w.row, w.col);
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (window_valid_o) begin
        if (q_win.size() == 0) begin
          chk(1'b0, "window_unexpected", $sformatf("got row %0d col %0d, required none", row_o, col_o));
        end else begin
          win_t w;
          w = q_win.pop_front();
          chk(cyc == w.tag && int'(row_o) == w.row && int'(col_o) == w.col && mask_o == w.mask,
              "window",
              $sformatf("got cyc %0d row %0d col %0d mask %h, required cyc %0d row %0d col %0d mask %h",
                        cyc, row_o, col_o, mask_o, w.tag, w.row, w.col, w.mask));
        end
      end
      if (flush_o) begin
        if (q_flush.size() == 0) chk(1'b0, "flush_unexpected", "got flush_o=1, required 0");
        else begin
          int t;
          t = q_flush.pop_front();
          chk(cyc == t, "flush_timing", $sformatf("got cyc %0d, required %0d", cyc, t));
        end
      end
      if (done_o) begin
        if (q_done.size() == 0) chk(1'b0, "done_unexpected", "got done_o=1, required 0");
        else begin
          int t;
          t = q_done.pop_front();
          chk(cyc == t, "done_timing", $sformatf("got cyc %0d, required %0d", cyc, t));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string where);
    chk(flush_o == 1'b0, {where, "_flush"}, $sformatf("got %b, required 0", flush_o));
    chk(busy_o == 1'b0, {where, "_busy"}, $sformatf("got %b, required 0", busy_o));
    chk(window_valid_o == 1'b0, {where, "_wvalid"}, $sformatf("got %b, required 0", window_valid_o));
    chk(row_o == 3'd0, {where, "_row"}, $sformatf("got %0d, required 0", row_o));
    chk(col_o == 3'd0, {where, "_col"}, $sformatf("got %0d, required 0", col_o));
    chk(mask_o == MASK_RESET, {where, "_mask"}, $sformatf("got %h, required %h", mask_o, MASK_RESET));
    chk(done_o == 1'b0, {where, "_done"}, $sformatf("got %b, required 0", done_o));
  endtask

  // mode 0: valid every cycle; 1: valid toggling; 2: random valid plus ignored start/valid noise
  task automatic run_frame(input int mode);
    int n;
    int e;
    n = 0;
    e = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (n < PIX) begin
      case (mode)
        0: valid_i = 1'b1;
        1: valid_i = ~valid_i;
        default: begin
          valid_i = 1'($urandom_range(0, 1));
          start_i = 1'($urandom_range(0, 1));
        end
      endcase
      tick();
      e = cyc;
      if (valid_i) begin
        n++;
        if (n >= COLS + 2) q_win.push_back(mk_win(n - COLS - 2, e));
      end
    end
    valid_i = 1'b0;
    start_i = 1'b0;
    for (int k = 0; k <= COLS; k++) begin
      q_flush.push_back(e + k);
      q_win.push_back(mk_win(PIX - COLS - 1 + k, e + k + 1));
    end
    q_done.push_back(e + COLS + 2);
    for (int k = 0; k < COLS + 2; k++) begin
      if (mode == 2) begin
        valid_i = 1'($urandom_range(0, 1));
        start_i = 1'($urandom_range(0, 1));
      end
      tick();
    end
    valid_i = 1'b0;
    start_i = 1'b0;
    tick();
    tick();
    chk(q_win.size() == 0, "windows_all_seen", $sformatf("got %0d pending, required 0", q_win.size()));
    chk(q_flush.size() == 0, "flush_all_seen", $sformatf("got %0d pending, required 0", q_flush.size()));
    chk(q_done.size() == 0, "done_seen", $sformatf("got %0d pending, required 0", q_done.size()));
    chk(busy_o == 1'b0, "idle_after_frame", $sformatf("got busy %b, required 0", busy_o));
  endtask

  task automatic reset_frame(input int n_in);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int n = 1; n <= n_in; n++) begin
      valid_i = 1'b1;
      tick();
      if (n >= COLS + 2) q_win.push_back(mk_win(n - COLS - 2, cyc));
    end
    valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    q_win.delete();
    q_flush.delete();
    q_done.delete();
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk(busy_o == 1'b0, "idle_after_reset", $sformatf("got busy %b, required 0", busy_o));
  endtask

  initial begin
    rst     = 1'b0;
    start_i = 1'b0;
    valid_i = 1'b0;
    #3;
    chk_reset_outputs("reset");
    tick();
    rst = 1'b1;
    tick();
    tick();
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(2);
    reset_frame(12);
    run_frame(0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
